gerador_palavra: RTL and testbench

- Transmitter counterpart to the word identifier: plays one word as a timed sequence of 4-bit notes with a one-cycle ok strobe per note.
- Drives the nota/ok interface that the identifier consumes, for bench self-checking and for the playback path.
- Word is selected by tipo and variante; emits fim when the last note has been strobed.

---
 rtl/pkg_palavras.sv | 41 ++++
 rtl/rom_palavras.sv | 35 +++
 rtl/gerador_palavra.sv | 164 ++++++++++++++++
 tb/tb_gerador_palavra.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/pkg_palavras.sv
// Shared definitions for the word generator and the word identifier.
// Holds the tipo codes, the generator FSM state codes, named note values
// and the word lengths per tipo.
package pkg_palavras;

    // tipo codes
    localparam logic [1:0] TIPO_INV  = 2'b00;
    localparam logic [1:0] TIPO_ADJ  = 2'b01;
    localparam logic [1:0] TIPO_COMP = 2'b10;
    localparam logic [1:0] TIPO_ADV  = 2'b11;

    // Generator FSM states; codes are visible on estado_atual
    typedef enum logic [2:0] {
        OCIOSO    = 3'b000,
        PREPARA   = 3'b001,
        PULSO     = 3'b010,
        INTERVALO = 3'b011,
        FIM       = 3'b100
    } estado_t;

    // Named notes {N3,N2,N1,D}
    localparam logic [3:0] LA_BAIXO = 4'b0110;
    localparam logic [3:0] SI_BAIXO = 4'b0111;
    localparam logic [3:0] DO_ALTO  = 4'b1000;

    // Word lengths in notes
    localparam logic [2:0] LEN_ADJ  = 3'd3;
    localparam logic [2:0] LEN_COMP = 3'd4;
    localparam logic [2:0] LEN_ADV  = 3'd4;

    // Invalid tipo reports length 1 so that index 0 is flagged as last.
    function automatic logic [2:0] comprimento(input logic [1:0] tipo);
        case (tipo)
            TIPO_ADJ:  comprimento = LEN_ADJ;
            TIPO_COMP: comprimento = LEN_COMP;
            TIPO_ADV:  comprimento = LEN_ADV;
            default:   comprimento = 3'd1;
        endcase
    endfunction

endpackage

// File: rtl/rom_palavras.sv
// Combinational word table.
// Ports:
//   tipo     - word class (01 adj, 10 comp, 11 adv, 00 invalid -> zero notes)
//   variante - which of the two words of the class
//   index    - note position inside the word
//   nota     - note at that position
//   ultima   - high when index is the last note of the word
module rom_palavras
    import pkg_palavras::*;
(
    input  logic [1:0] tipo,
    input  logic       variante,
    input  logic [1:0] index,
    output logic [3:0] nota,
    output logic       ultima
);

    logic [3:0] palavra [4];

    always_comb begin
        palavra = '{4'b0000, 4'b0000, 4'b0000, 4'b0000};
        case ({tipo, variante})
            {TIPO_ADJ, 1'b0}:  palavra = '{4'b0001, 4'b0011, LA_BAIXO, 4'b0000};
            {TIPO_ADJ, 1'b1}:  palavra = '{4'b0010, 4'b0011, SI_BAIXO, 4'b0000};
            {TIPO_COMP, 1'b0}: palavra = '{4'b0100, 4'b0101, LA_BAIXO, DO_ALTO};
            {TIPO_COMP, 1'b1}: palavra = '{4'b1001, 4'b1011, 4'b1010, SI_BAIXO};
            {TIPO_ADV, 1'b0}:  palavra = '{4'b1100, 4'b1101, LA_BAIXO, SI_BAIXO};
            {TIPO_ADV, 1'b1}:  palavra = '{4'b1110, 4'b1111, LA_BAIXO, SI_BAIXO};
            default:           palavra = '{4'b0000, 4'b0000, 4'b0000, 4'b0000};
        endcase
        nota   = palavra[index];
        ultima = ({1'b0, index} == (comprimento(tipo) - 3'd1));
    end

endmodule

// File: rtl/gerador_palavra.sv
// Word generator: plays one word as a timed sequence of 4-bit notes, each
// held SETUP_CYCLES cycles, strobed with ok for one cycle, then followed by
// GAP_CYCLES quiet cycles. fim pulses once after the last gap.
// Ports:
//   clk, reset        - clock, synchronous active-high reset
//   iniciar           - start request (only honoured when idle)
//   tipo, variante    - word selection, latched on start
//   cancelar          - abort the word in progress
//   nota, ok          - note and its one-cycle valid strobe
//   ocupado           - a word is in progress
//   fim, erro         - end-of-word pulse, invalid-tipo pulse
//   estado_atual      - FSM state code
module gerador_palavra
    import pkg_palavras::*;
#(
    parameter int unsigned SETUP_CYCLES = 2,
    parameter int unsigned GAP_CYCLES   = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       iniciar,
    input  logic [1:0] tipo,
    input  logic       variante,
    input  logic       cancelar,
    output logic [3:0] nota,
    output logic       ok,
    output logic       ocupado,
    output logic       fim,
    output logic       erro,
    output logic [2:0] estado_atual
);

    localparam int unsigned MAXC = (SETUP_CYCLES > GAP_CYCLES) ? SETUP_CYCLES : GAP_CYCLES;
    localparam int unsigned CW   = $clog2(MAXC + 1);

    estado_t       estado_q, estado_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    idx_q, idx_d;
    logic [3:0]    nota_q, nota_d;
    logic          ultima_q, ultima_d;
    logic [1:0]    tipo_q, tipo_d;
    logic          var_q, var_d;
    logic          erro_q, erro_d;

    logic [1:0]    rom_tipo;
    logic          rom_var;
    logic [1:0]    rom_idx;
    logic [3:0]    rom_nota;
    logic          rom_ultima;

    // The ROM always looks up the note that would be loaded next: note 0 of
    // the live selection while idle, else the following note of the word.
    assign rom_tipo = (estado_q == OCIOSO) ? tipo     : tipo_q;
    assign rom_var  = (estado_q == OCIOSO) ? variante : var_q;
    assign rom_idx  = (estado_q == OCIOSO) ? 2'd0     : idx_q + 2'd1;

    rom_palavras u_rom (
        .tipo     (rom_tipo),
        .variante (rom_var),
        .index    (rom_idx),
        .nota     (rom_nota),
        .ultima   (rom_ultima)
    );

    always_comb begin
        estado_d = estado_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        nota_d   = nota_q;
        ultima_d = ultima_q;
        tipo_d   = tipo_q;
        var_d    = var_q;
        erro_d   = 1'b0;

        case (estado_q)
            OCIOSO: begin
                if (iniciar && !cancelar) begin
                    if (tipo != TIPO_INV) begin
                        tipo_d   = tipo;
                        var_d    = variante;
                        idx_d    = 2'd0;
                        cnt_d    = '0;
                        nota_d   = rom_nota;
                        ultima_d = rom_ultima;
                        estado_d = PREPARA;
                    end else begin
                        erro_d = 1'b1;
                    end
                end
            end
            PREPARA: begin
                if (cnt_q == CW'(SETUP_CYCLES - 1)) begin
                    cnt_d    = '0;
                    estado_d = PULSO;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            PULSO: begin
                estado_d = INTERVALO;
            end
            INTERVALO: begin
                if (cnt_q == CW'(GAP_CYCLES - 1)) begin
                    cnt_d = '0;
                    if (ultima_q) begin
                        estado_d = FIM;
                    end else begin
                        idx_d    = idx_q + 2'd1;
                        nota_d   = rom_nota;
                        ultima_d = rom_ultima;
                        estado_d = PREPARA;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            FIM: begin
                estado_d = OCIOSO;
            end
            default: begin
                estado_d = OCIOSO;
            end
        endcase

        // Abort keeps the note on the bus but drops everything else.
        if (cancelar && (estado_q != OCIOSO)) begin
            estado_d = OCIOSO;
            cnt_d    = '0;
            idx_d    = 2'd0;
            nota_d   = nota_q;
            ultima_d = ultima_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            estado_q <= OCIOSO;
            cnt_q    <= '0;
            idx_q    <= 2'd0;
            nota_q   <= 4'b0000;
            ultima_q <= 1'b0;
            tipo_q   <= TIPO_INV;
            var_q    <= 1'b0;
            erro_q   <= 1'b0;
        end else begin
            estado_q <= estado_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            nota_q   <= nota_d;
            ultima_q <= ultima_d;
            tipo_q   <= tipo_d;
            var_q    <= var_d;
            erro_q   <= erro_d;
        end
    end

    assign nota         = nota_q;
    assign ok           = (estado_q == PULSO);
    assign ocupado      = (estado_q != OCIOSO);
    assign fim          = (estado_q == FIM);
    assign erro         = erro_q;
    assign estado_atual = estado_q;

endmodule

// File: tb/tb_gerador_palavra.sv
module tb_gerador_palavra;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    // DUT a: default timing (2/2); DUT b: tight timing (1/1)
    logic       ini_a, var_a, can_a, ini_b, var_b, can_b;
    logic [1:0] tipo_a, tipo_b;
    logic [3:0] nota_a, nota_b;
    logic       ok_a, ok_b, ocup_a, ocup_b, fim_a, fim_b, erro_a, erro_b;
    logic [2:0] est_a, est_b;

    gerador_palavra #(.SETUP_CYCLES(2), .GAP_CYCLES(2)) dut_a (
        .clk(clk), .reset(reset), .iniciar(ini_a), .tipo(tipo_a), .variante(var_a),
        .cancelar(can_a), .nota(nota_a), .ok(ok_a), .ocupado(ocup_a), .fim(fim_a),
        .erro(erro_a), .estado_atual(est_a)
    );

    gerador_palavra #(.SETUP_CYCLES(1), .GAP_CYCLES(1)) dut_b (
        .clk(clk), .reset(reset), .iniciar(ini_b), .tipo(tipo_b), .variante(var_b),
        .cancelar(can_b), .nota(nota_b), .ok(ok_b), .ocupado(ocup_b), .fim(fim_b),
        .erro(erro_b), .estado_atual(est_b)
    );

    bit sel;
    logic [3:0] m_nota;
    logic       m_ok, m_ocup, m_fim;
    logic [2:0] m_est;
    assign m_nota = sel ? nota_b : nota_a;
    assign m_ok   = sel ? ok_b   : ok_a;
    assign m_ocup = sel ? ocup_b : ocup_a;
    assign m_fim  = sel ? fim_b  : fim_a;
    assign m_est  = sel ? est_b  : est_a;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0] tipo;
        logic       vr;
        int         len;
        int         poke;   // cycle at which a stray iniciar is injected (0 = none)
        logic [3:0] n [4];
    } vec_t;

    vec_t tbl [6];

    function automatic vec_t mk(input logic [1:0] t, input logic v, input int l, input int p,
                                input logic [3:0] a, input logic [3:0] b,
                                input logic [3:0] c, input logic [3:0] d);
        vec_t r;
        r.tipo = t; r.vr = v; r.len = l; r.poke = p;
        r.n[0] = a; r.n[1] = b; r.n[2] = c; r.n[3] = d;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic ini, input logic [1:0] t, input logic v, input logic c);
        if (sel) begin
            ini_b = ini; tipo_b = t; var_b = v; can_b = c;
        end else begin
            ini_a = ini; tipo_a = t; var_a = v; can_a = c;
        end
    endtask

    // Plays one word and checks notes, strobe timing, fim timing and
    // invariants. Cycle 1 is the first cycle after the start is sampled.
    task automatic run_word(input vec_t v, input int s, input int g);
        int c, nok, fimc, bad_cons, bad_ovl, bad_busy;
        logic prev_ok;
        logic [3:0] got [4];
        int okc [4];
        for (int k = 0; k < 4; k++) begin
            got[k] = 4'hx; okc[k] = -1;
        end
        drive(1'b1, v.tipo, v.vr, 1'b0);
        tick();
        drive(1'b0, v.tipo, v.vr, 1'b0);
        c = 1; nok = 0; fimc = -1; bad_cons = 0; bad_ovl = 0; bad_busy = 0; prev_ok = 1'b0;
        while (c < 60 && fimc < 0) begin
            if (m_ok) begin
                if (nok < 4) begin
                    got[nok] = m_nota;
                    okc[nok] = c;
                end
                nok++;
            end
            if (m_ok && prev_ok) bad_cons++;
            if (m_ok && m_fim) bad_ovl++;
            if (!m_ocup) bad_busy++;
            if (m_fim) fimc = c;
            prev_ok = m_ok;
            if (fimc < 0) begin
                // stray start request with a different selection; must be ignored
                if (c == v.poke) drive(1'b1, 2'b11, ~v.vr, 1'b0);
                else drive(1'b0, v.tipo, v.vr, 1'b0);
                tick();
                c++;
            end
        end
        drive(1'b0, v.tipo, v.vr, 1'b0);
        chk("strobe count", nok, v.len);
        for (int k = 0; k < v.len; k++) begin
            chk($sformatf("note %0d", k), got[k], v.n[k]);
            chk($sformatf("ok cycle %0d", k), okc[k], s + 1 + k * (s + 1 + g));
        end
        chk("fim cycle", fimc, v.len * (s + 1 + g) + 1);
        chk("ok consecutive", bad_cons, 0);
        chk("ok with fim", bad_ovl, 0);
        chk("ocupado dropped", bad_busy, 0);
        tick();
        chk("idle after fim", m_est, 3'b000);
        chk("ocupado after fim", m_ocup, 1'b0);
        chk("fim single", m_fim, 1'b0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " estado"}, est_a, 3'b000);
        chk({tag, " nota"}, nota_a, 4'b0000);
        chk({tag, " ok"}, ok_a, 1'b0);
        chk({tag, " ocupado"}, ocup_a, 1'b0);
        chk({tag, " fim"}, fim_a, 1'b0);
        chk({tag, " erro"}, erro_a, 1'b0);
    endtask

    initial begin
        int n_ok, n_fim;
        sel = 1'b0;
        reset = 1'b1;
        ini_a = 0; tipo_a = 0; var_a = 0; can_a = 0;
        ini_b = 0; tipo_b = 0; var_b = 0; can_b = 0;
        tick();
        tick();
        chk_reset_vals("reset");
        chk("reset b estado", est_b, 3'b000);
        reset = 1'b0;
        tick();

        tbl[0] = mk(2'b01, 1'b0, 3, 0, 4'b0001, 4'b0011, 4'b0110, 4'b0000);
        tbl[1] = mk(2'b01, 1'b1, 3, 4, 4'b0010, 4'b0011, 4'b0111, 4'b0000);
        tbl[2] = mk(2'b10, 1'b1, 4, 0, 4'b1001, 4'b1011, 4'b1010, 4'b0111);
        tbl[3] = mk(2'b10, 1'b0, 4, 9, 4'b0100, 4'b0101, 4'b0110, 4'b1000);
        tbl[4] = mk(2'b11, 1'b0, 4, 0, 4'b1100, 4'b1101, 4'b0110, 4'b0111);
        tbl[5] = mk(2'b11, 1'b1, 4, 0, 4'b1110, 4'b1111, 4'b0110, 4'b0111);

        // back to back: each start lands in the cycle right after fim
        for (int i = 0; i < 6; i++) run_word(tbl[i], 2, 2);

        // invalid tipo
        drive(1'b1, 2'b00, 1'b0, 1'b0);
        tick();
        drive(1'b0, 2'b00, 1'b0, 1'b0);
        chk("erro pulse", erro_a, 1'b1);
        chk("erro ocupado", ocup_a, 1'b0);
        chk("erro estado", est_a, 3'b000);
        tick();
        chk("erro one cycle", erro_a, 1'b0);
        chk("erro no ok", ok_a, 1'b0);

        // cancel during the second strobe of comp v0
        drive(1'b1, 2'b10, 1'b0, 1'b0);
        tick();
        drive(1'b0, 2'b10, 1'b0, 1'b0);
        repeat (7) tick();
        chk("pre-cancel ok", ok_a, 1'b1);
        chk("pre-cancel nota", nota_a, 4'b0101);
        drive(1'b0, 2'b10, 1'b0, 1'b1);
        tick();
        drive(1'b0, 2'b10, 1'b0, 1'b0);
        chk("cancel estado", est_a, 3'b000);
        chk("cancel ok", ok_a, 1'b0);
        chk("cancel ocupado", ocup_a, 1'b0);
        chk("cancel nota", nota_a, 4'b0101);
        n_ok = 0; n_fim = 0;
        for (int i = 0; i < 20; i++) begin
            if (ok_a) n_ok++;
            if (fim_a) n_fim++;
            tick();
        end
        chk("cancel no fim", n_fim, 0);
        chk("cancel no ok", n_ok, 0);

        // cancel and start together while idle
        drive(1'b1, 2'b01, 1'b0, 1'b1);
        tick();
        drive(1'b0, 2'b01, 1'b0, 1'b0);
        chk("cancel beats start", est_a, 3'b000);
        chk("cancel beats start ocupado", ocup_a, 1'b0);

        // reset mid-INTERVALO
        drive(1'b1, 2'b01, 1'b0, 1'b0);
        tick();
        drive(1'b0, 2'b01, 1'b0, 1'b0);
        repeat (3) tick();
        chk("in intervalo", est_a, 3'b011);
        reset = 1'b1;
        tick();
        chk_reset_vals("mid reset");
        reset = 1'b0;

        // reset together with start
        reset = 1'b1;
        drive(1'b1, 2'b11, 1'b1, 1'b0);
        tick();
        reset = 1'b0;
        drive(1'b0, 2'b11, 1'b1, 1'b0);
        chk_reset_vals("reset+start");
        tick();
        chk("start ignored", est_a, 3'b000);

        // tight timing instance: 3-cycle note spacing
        sel = 1'b1;
        run_word(tbl[0], 1, 1);
        run_word(tbl[4], 1, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
